// File: rtl/result_accumulator.sv
// Signed saturating accumulator behind the 4-bit add/subtract unit.
// Folds BURST accepted results into a total and offers it on a valid/ready port.
module result_accumulator #(
    parameter int ACC_W = 8,
    parameter int BURST = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enb,
    input  logic [1:0]       modo,
    input  logic [3:0]       Q,
    input  logic             RCO,
    input  logic             out_ready,
    output logic             busy,
    output logic             out_valid,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_sat,
    output logic [3:0]       op_count
);

    typedef enum logic {
        ST_ACCUM  = 1'b0,
        ST_REPORT = 1'b1
    } state_t;

    localparam logic [3:0] BURST_C = 4'(BURST);

    state_t           state_r;
    logic [ACC_W-1:0] acc_r;
    logic             sat_r;
    logic [3:0]       cnt_r;

    logic [ACC_W:0]   operand_s;
    logic [ACC_W:0]   sum_s;
    logic             ovf_s;
    logic [ACC_W-1:0] clamped_s;
    logic [ACC_W-1:0] load_s;
    logic [3:0]       next_cnt_s;

    // Clamp an ACC_W+1 bit sum to the signed ACC_W range.
    function automatic logic [ACC_W-1:0] sat_clamp(input logic [ACC_W:0] s);
        if (s[ACC_W] != s[ACC_W-1]) begin
            sat_clamp = s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            sat_clamp = s[ACC_W-1:0];
        end
    endfunction

    // Operand decode and saturating sum; subtract treats {RCO,Q} as a signed 5-bit value.
    always_comb begin
        operand_s = {(ACC_W+1){1'b0}};
        if (modo == 2'b01) begin
            operand_s = {{(ACC_W-4){RCO}}, RCO, Q};
        end else begin
            operand_s = {{(ACC_W-4){1'b0}}, RCO, Q};
        end
        sum_s      = {acc_r[ACC_W-1], acc_r} + operand_s;
        ovf_s      = sum_s[ACC_W] ^ sum_s[ACC_W-1];
        clamped_s  = sat_clamp(sum_s);
        load_s     = {{(ACC_W-5){1'b0}}, RCO, Q};
        next_cnt_s = cnt_r + 4'd1;
    end

    // Burst state machine together with accumulator, sticky saturation and op counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_ACCUM;
            acc_r   <= {ACC_W{1'b0}};
            sat_r   <= 1'b0;
            cnt_r   <= 4'd0;
        end else begin
            case (state_r)
                ST_ACCUM: begin
                    if (enb) begin
                        case (modo)
                            2'b00, 2'b01: begin
                                acc_r <= clamped_s;
                                sat_r <= sat_r | ovf_s;
                                cnt_r <= next_cnt_s;
                                if (next_cnt_s == BURST_C) begin
                                    state_r <= ST_REPORT;
                                end
                            end
                            2'b10: begin
                                acc_r <= load_s;
                                sat_r <= 1'b0;
                                cnt_r <= next_cnt_s;
                                if (next_cnt_s == BURST_C) begin
                                    state_r <= ST_REPORT;
                                end
                            end
                            default: begin
                                acc_r <= {ACC_W{1'b0}};
                                sat_r <= 1'b0;
                                cnt_r <= 4'd0;
                            end
                        endcase
                    end
                end
                ST_REPORT: begin
                    // enb is deliberately ignored here, including on the handshake edge.
                    if (out_ready) begin
                        state_r <= ST_ACCUM;
                        acc_r   <= {ACC_W{1'b0}};
                        sat_r   <= 1'b0;
                        cnt_r   <= 4'd0;
                    end
                end
                default: begin
                    state_r <= ST_ACCUM;
                end
            endcase
        end
    end

    assign busy      = (state_r == ST_REPORT);
    assign out_valid = (state_r == ST_REPORT);
    assign out_acc   = acc_r;
    assign out_sat   = sat_r;
    assign op_count  = cnt_r;

endmodule

// File: tb/tb_result_accumulator.sv
// Directed self-checking bench for result_accumulator (BURST=4 and BURST=8 instances).
module tb_result_accumulator;

    logic       clk = 1'b0;
    logic       reset;
    logic       enb;
    logic [1:0] modo;
    logic [3:0] Q;
    logic       RCO;
    logic       out_ready;
    logic       out_ready8;

    logic       busy4, valid4, sat4;
    logic [7:0] acc4;
    logic [3:0] cnt4;
    logic       busy8, valid8, sat8;
    logic [7:0] acc8;
    logic [3:0] cnt8;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    result_accumulator #(.ACC_W(8), .BURST(4)) u_acc4 (
        .clk(clk), .reset(reset), .enb(enb), .modo(modo), .Q(Q), .RCO(RCO),
        .out_ready(out_ready), .busy(busy4), .out_valid(valid4), .out_acc(acc4),
        .out_sat(sat4), .op_count(cnt4)
    );

    result_accumulator #(.ACC_W(8), .BURST(8)) u_acc8 (
        .clk(clk), .reset(reset), .enb(enb), .modo(modo), .Q(Q), .RCO(RCO),
        .out_ready(out_ready8), .busy(busy8), .out_valid(valid8), .out_acc(acc8),
        .out_sat(sat8), .op_count(cnt8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic e, input logic [1:0] m, input logic [3:0] qq, input logic r);
        enb  = e;
        modo = m;
        Q    = qq;
        RCO  = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 1: reset with random inputs
        reset      = 1'b1;
        out_ready  = 1'($urandom_range(1));
        out_ready8 = 1'b1;
        cyc(1'($urandom_range(1)), 2'($urandom_range(3)), 4'($urandom_range(15)), 1'($urandom_range(1)));
        check("rst_acc", acc4, 8'h00);
        check("rst_cnt", cnt4, 4'd0);
        check("rst_valid", valid4, 1'b0);
        check("rst_busy", busy4, 1'b0);
        check("rst_sat", sat4, 1'b0);
        check("rst_acc8", acc8, 8'h00);
        reset     = 1'b0;
        out_ready = 1'b1;

        // 2: four adds of 5
        cyc(1'b1, 2'b00, 4'h5, 1'b0);
        check("add1_acc", acc4, 8'd5);
        check("add1_cnt", cnt4, 4'd1);
        check("add1_valid", valid4, 1'b0);
        cyc(1'b1, 2'b00, 4'h5, 1'b0);
        cyc(1'b1, 2'b00, 4'h5, 1'b0);
        check("add3_valid", valid4, 1'b0);
        cyc(1'b1, 2'b00, 4'h5, 1'b0);
        check("add4_valid", valid4, 1'b1);
        check("add4_busy", busy4, 1'b1);
        check("add4_acc", acc4, 8'd20);
        check("add4_sat", sat4, 1'b0);
        check("add4_cnt", cnt4, 4'd4);
        cyc(1'b0, 2'b00, 4'h0, 1'b0);
        check("hs_valid", valid4, 1'b0);
        check("hs_acc", acc4, 8'd0);
        check("hs_cnt", cnt4, 4'd0);

        // 3: subtracts -3 +2 -16 +15
        cyc(1'b1, 2'b01, 4'hD, 1'b1);
        check("sub1_acc", acc4, 8'hFD);
        cyc(1'b1, 2'b01, 4'h2, 1'b0);
        cyc(1'b1, 2'b01, 4'h0, 1'b1);
        check("sub3_acc", acc4, 8'hEF);
        cyc(1'b1, 2'b01, 4'hF, 1'b0);
        check("sub4_valid", valid4, 1'b1);
        check("sub4_acc", acc4, 8'hFE);
        cyc(1'b0, 2'b00, 4'h0, 1'b0);
        check("sub_hs_valid", valid4, 1'b0);

        // 4: saturation on the BURST=8 instance
        reset = 1'b1;
        cyc(1'b0, 2'b00, 4'h0, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) cyc(1'b1, 2'b00, 4'hF, 1'b1);
        check("sat4_acc8", acc8, 8'd124);
        check("sat4_flag8", sat8, 1'b0);
        cyc(1'b1, 2'b00, 4'hF, 1'b1);
        check("sat5_acc8", acc8, 8'd127);
        check("sat5_flag8", sat8, 1'b1);
        check("sat5_valid8", valid8, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 2'b00, 4'hF, 1'b1);
        check("sat8_valid8", valid8, 1'b1);
        check("sat8_acc8", acc8, 8'h7F);
        check("sat8_flag8", sat8, 1'b1);
        check("sat8_cnt8", cnt8, 4'd8);
        cyc(1'b0, 2'b00, 4'h0, 1'b0);
        check("sat_hs_flag8", sat8, 1'b0);
        check("sat_hs_valid8", valid8, 1'b0);
        // exactly reaching the negative limit is not saturation
        for (int i = 0; i < 8; i++) cyc(1'b1, 2'b01, 4'h0, 1'b1);
        check("neg_valid8", valid8, 1'b1);
        check("neg_acc8", acc8, 8'h80);
        check("neg_flag8", sat8, 1'b0);
        cyc(1'b0, 2'b00, 4'h0, 1'b0);

        // 5: backpressure on the BURST=4 instance
        reset = 1'b1;
        cyc(1'b0, 2'b00, 4'h0, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) cyc(1'b1, 2'b00, 4'h1, 1'b0);
        check("bp_valid", valid4, 1'b1);
        check("bp_acc", acc4, 8'd4);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 2'b00, 4'(i + 2), 1'b0);
            check("bp_busy", busy4, 1'b1);
            check("bp_hold_valid", valid4, 1'b1);
            check("bp_hold_acc", acc4, 8'd4);
            check("bp_hold_cnt", cnt4, 4'd4);
        end
        out_ready = 1'b1;
        cyc(1'b1, 2'b00, 4'h7, 1'b0);
        check("bp_rel_valid", valid4, 1'b0);
        check("bp_rel_busy", busy4, 1'b0);
        check("bp_rel_cnt", cnt4, 4'd0);
        check("bp_rel_acc", acc4, 8'd0);

        // load, subtract, clear
        cyc(1'b1, 2'b10, 4'h9, 1'b1);
        check("load_acc", acc4, 8'h19);
        check("load_cnt", cnt4, 4'd1);
        cyc(1'b1, 2'b01, 4'h0, 1'b1);
        check("load_sub_acc", acc4, 8'h09);

        // 6: clear mid-burst restarts the burst
        cyc(1'b1, 2'b11, 4'h5, 1'b1);
        check("clr0_cnt", cnt4, 4'd0);
        cyc(1'b1, 2'b00, 4'h3, 1'b0);
        cyc(1'b1, 2'b00, 4'h3, 1'b0);
        check("pre_clr_acc", acc4, 8'd6);
        check("pre_clr_cnt", cnt4, 4'd2);
        cyc(1'b1, 2'b11, 4'h0, 1'b0);
        check("clr_acc", acc4, 8'd0);
        check("clr_cnt", cnt4, 4'd0);
        check("clr_valid", valid4, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 2'b00, 4'h1, 1'b0);
        check("clr3_valid", valid4, 1'b0);
        check("clr3_cnt", cnt4, 4'd3);
        cyc(1'b1, 2'b00, 4'h1, 1'b0);
        check("clr4_valid", valid4, 1'b1);
        check("clr4_acc", acc4, 8'd4);
        cyc(1'b0, 2'b00, 4'h0, 1'b0);

        // reset during REPORT drops the pending result
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) cyc(1'b1, 2'b00, 4'h2, 1'b0);
        check("rr_valid", valid4, 1'b1);
        check("rr_acc", acc4, 8'd8);
        reset     = 1'b1;
        out_ready = 1'b1;
        cyc(1'b0, 2'b00, 4'h0, 1'b0);
        check("rr_after_valid", valid4, 1'b0);
        check("rr_after_acc", acc4, 8'd0);
        check("rr_after_busy", busy4, 1'b0);
        reset = 1'b0;
        cyc(1'b0, 2'b00, 4'h0, 1'b0);
        check("rr_idle_valid", valid4, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
